// File: rtl/trap_sequencer.sv
// Trap-entry/mret sequencer: latches one execute event, commits it to the CSR unit, reads mtvec/mepc and redirects fetch.
// Latency: command 1 cycle after the event, redirect_valid after 3, flush 1 cycle after the redirect handshake; holds in REDIRECT while redirect_ready is low.
module trap_sequencer #(
    parameter int                        CSR_ADDR_WIDTH = 12,
    parameter logic [CSR_ADDR_WIDTH-1:0] MTVEC_ADDR     = 12'h305,
    parameter logic [CSR_ADDR_WIDTH-1:0] MEPC_ADDR      = 12'h341
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ecall,
    input  logic                      ebreak,
    input  logic                      mret,
    input  logic                      is_misaligned,
    input  logic                      is_misalignment_store,
    input  logic [31:0]               pc,
    input  logic [31:0]               instr,
    input  logic [11:0]               mem_addr,
    input  logic [4:0]                rd_addr,
    output logic                      csr_ecall,
    output logic                      csr_ebreak,
    output logic                      csr_mret,
    output logic                      csr_misaligned,
    output logic                      csr_misalignment_store,
    output logic [31:0]               csr_pc,
    output logic [31:0]               csr_in,
    output logic [11:0]               csr_mem_addr,
    output logic [4:0]                csr_rd_addr,
    output logic                      csr_r_en,
    output logic [CSR_ADDR_WIDTH-1:0] csr_addr,
    input  logic [31:0]               csr_rdata,
    output logic                      stall,
    output logic                      flush,
    output logic                      redirect_valid,
    input  logic                      redirect_ready,
    output logic [31:0]               redirect_pc,
    output logic [31:0]               trap_count
);

    typedef enum logic [1:0] {IDLE, COMMIT, READ, REDIRECT} state_t;

    state_t r_state;
    logic   r_is_mret;
    logic   w_any_event;

    assign w_any_event = rst && (ecall || ebreak || mret || is_misaligned);
    assign stall       = (r_state != IDLE) || w_any_event;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state                <= IDLE;
            r_is_mret              <= 1'b0;
            csr_ecall              <= 1'b0;
            csr_ebreak             <= 1'b0;
            csr_mret               <= 1'b0;
            csr_misaligned         <= 1'b0;
            csr_misalignment_store <= 1'b0;
            csr_pc                 <= '0;
            csr_in                 <= '0;
            csr_mem_addr           <= '0;
            csr_rd_addr            <= '0;
            csr_r_en               <= 1'b0;
            csr_addr               <= '0;
            flush                  <= 1'b0;
            redirect_valid         <= 1'b0;
            redirect_pc            <= '0;
            trap_count             <= '0;
        end else begin
            csr_ecall              <= 1'b0;
            csr_ebreak             <= 1'b0;
            csr_mret               <= 1'b0;
            csr_misaligned         <= 1'b0;
            csr_misalignment_store <= 1'b0;
            csr_r_en               <= 1'b0;
            csr_addr               <= '0;
            flush                  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any_event) begin
                        csr_pc       <= pc;
                        csr_in       <= instr;
                        csr_mem_addr <= mem_addr;
                        csr_rd_addr  <= rd_addr;
                        r_is_mret    <= 1'b0;
                        // Highest-priority event wins; the rest are dropped
                        if (is_misaligned) begin
                            csr_misaligned         <= 1'b1;
                            csr_misalignment_store <= is_misalignment_store;
                        end else if (ebreak) begin
                            csr_ebreak <= 1'b1;
                        end else if (ecall) begin
                            csr_ecall <= 1'b1;
                        end else begin
                            csr_mret  <= 1'b1;
                            r_is_mret <= 1'b1;
                        end
                        r_state <= COMMIT;
                    end
                end
                COMMIT: begin
                    csr_r_en <= 1'b1;
                    csr_addr <= r_is_mret ? MEPC_ADDR : MTVEC_ADDR;
                    r_state  <= READ;
                end
                READ: begin
                    // Synchronous exceptions always use the base, so mode bits are simply masked
                    redirect_pc    <= csr_rdata & 32'hFFFF_FFFC;
                    redirect_valid <= 1'b1;
                    if (!r_is_mret) begin
                        trap_count <= trap_count + 32'd1;
                    end
                    r_state <= REDIRECT;
                end
                REDIRECT: begin
                    if (redirect_ready) begin
                        redirect_valid <= 1'b0;
                        flush          <= 1'b1;
                        r_state        <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_trap_sequencer.sv
// Randomized scoreboard bench for trap_sequencer with a CSR read model and a transaction-level reference.
module tb_trap_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ecall = 0, ebreak = 0, mret = 0, is_misaligned = 0, is_misalignment_store = 0;
    logic [31:0] pc = 0, instr = 0;
    logic [11:0] mem_addr = 0;
    logic [4:0]  rd_addr = 0;
    logic        csr_ecall, csr_ebreak, csr_mret, csr_misaligned, csr_misalignment_store;
    logic [31:0] csr_pc, csr_in;
    logic [11:0] csr_mem_addr;
    logic [4:0]  csr_rd_addr;
    logic        csr_r_en;
    logic [11:0] csr_addr;
    logic [31:0] csr_rdata;
    logic        stall, flush, redirect_valid;
    logic        redirect_ready = 1'b0;
    logic [31:0] redirect_pc, trap_count;

    logic [31:0] m_mtvec = 0, m_mepc = 0;
    int          ready_mode = 1;
    int unsigned cyc = 0;
    int          n_chk = 0, n_pass = 0;
    int unsigned model_cnt = 0;

    trap_sequencer dut (
        .clk(clk), .rst(rst), .ecall(ecall), .ebreak(ebreak), .mret(mret),
        .is_misaligned(is_misaligned), .is_misalignment_store(is_misalignment_store),
        .pc(pc), .instr(instr), .mem_addr(mem_addr), .rd_addr(rd_addr),
        .csr_ecall(csr_ecall), .csr_ebreak(csr_ebreak), .csr_mret(csr_mret),
        .csr_misaligned(csr_misaligned), .csr_misalignment_store(csr_misalignment_store),
        .csr_pc(csr_pc), .csr_in(csr_in), .csr_mem_addr(csr_mem_addr), .csr_rd_addr(csr_rd_addr),
        .csr_r_en(csr_r_en), .csr_addr(csr_addr), .csr_rdata(csr_rdata),
        .stall(stall), .flush(flush), .redirect_valid(redirect_valid),
        .redirect_ready(redirect_ready), .redirect_pc(redirect_pc), .trap_count(trap_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // CSR unit model: combinational read of mtvec/mepc
    assign csr_rdata = !csr_r_en ? 32'h0 :
                       (csr_addr == 12'h305) ? m_mtvec :
                       (csr_addr == 12'h341) ? m_mepc : 32'hDEAD_BEEF;

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: redirect_ready = 1'($urandom % 2);
            1: redirect_ready = 1'b1;
            default: redirect_ready = 1'b0;
        endcase
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    typedef struct {
        logic [4:0]  cmd;   // {misaligned, store, ebreak, ecall, mret}
        logic [31:0] pc;
        logic [31:0] instr;
        logic [11:0] maddr;
        logic [4:0]  rd;
        logic [11:0] caddr;
        logic [31:0] target;
        logic [31:0] cnt;
        int unsigned icyc;
    } exp_t;

    exp_t q[$];

    function automatic logic [255:0] all_outs();
        return {csr_ecall, csr_ebreak, csr_mret, csr_misaligned, csr_misalignment_store,
                csr_pc, csr_in, csr_mem_addr, csr_rd_addr, csr_r_en, csr_addr,
                stall, flush, redirect_valid, redirect_pc, trap_count};
    endfunction

    // Monitor: pops expectations when the DUT commits and checks read, redirect and flush
    exp_t        cur;
    logic        busy = 0, pend_flush = 0, seen_valid = 0, unstable = 0;
    int unsigned cmd_cyc = 0;
    logic [31:0] first_pc = 0;
    logic [4:0]  w_cmd;

    always @(negedge clk) begin
        if (!rst) begin
            busy = 0; pend_flush = 0; seen_valid = 0;
        end else begin
            w_cmd = {csr_misaligned, csr_misalignment_store, csr_ebreak, csr_ecall, csr_mret};
            if (pend_flush) begin
                chk("flush_pulse", 256'(flush), 256'(1));
                pend_flush = 0;
            end else if (flush) begin
                chk("spurious_flush", 256'(flush), 256'(0));
            end
            if (w_cmd != 0) begin
                if (busy || q.size() == 0) begin
                    chk("unexpected_cmd", 256'(w_cmd), 256'(0));
                end else begin
                    cur = q.pop_front();
                    busy = 1; cmd_cyc = cyc; seen_valid = 0; unstable = 0;
                    chk("cmd_bits", 256'(w_cmd), 256'(cur.cmd));
                    chk("csr_pc", 256'(csr_pc), 256'(cur.pc));
                    chk("csr_in", 256'(csr_in), 256'(cur.instr));
                    chk("csr_mem_addr", 256'(csr_mem_addr), 256'(cur.maddr));
                    chk("csr_rd_addr", 256'(csr_rd_addr), 256'(cur.rd));
                    chk("cmd_latency", 256'(cyc), 256'(cur.icyc + 1));
                    chk("stall_in_commit", 256'(stall), 256'(1));
                end
            end
            if (csr_r_en) begin
                if (!busy) chk("unexpected_ren", 256'(csr_r_en), 256'(0));
                else begin
                    chk("csr_addr", 256'(csr_addr), 256'(cur.caddr));
                    chk("read_latency", 256'(cyc), 256'(cmd_cyc + 1));
                end
            end else if (csr_addr != 0) begin
                chk("csr_addr_idle", 256'(csr_addr), 256'(0));
            end
            if (redirect_valid) begin
                if (!busy) chk("unexpected_valid", 256'(redirect_valid), 256'(0));
                else begin
                    if (!seen_valid) begin
                        seen_valid = 1; first_pc = redirect_pc;
                        chk("valid_latency", 256'(cyc), 256'(cmd_cyc + 2));
                    end else if (redirect_pc !== first_pc) begin
                        unstable = 1;
                    end
                    if (redirect_ready) begin
                        chk("redirect_pc", 256'(redirect_pc), 256'(cur.target));
                        chk("redirect_pc_stable", 256'(unstable), 256'(0));
                        chk("trap_count", 256'(trap_count), 256'(cur.cnt));
                        chk("stall_at_handshake", 256'(stall), 256'(1));
                        busy = 0; pend_flush = 1;
                    end
                end
            end
        end
    end

    task automatic wait_idle();
        int k = 0;
        while (stall && k < 200) begin @(posedge clk); #1; k++; end
        if (stall) chk("idle_timeout", 256'(stall), 256'(0));
    endtask

    // ev = {misaligned, ebreak, ecall, mret}
    task automatic issue(input logic [3:0] ev, input logic st, input logic [31:0] p, input logic [31:0] ins,
                         input logic [11:0] ma, input logic [4:0] rd, input logic [31:0] tv, input logic [31:0] ep);
        exp_t e;
        wait_idle();
        m_mtvec = tv; m_mepc = ep;
        e.pc = p; e.instr = ins; e.maddr = ma; e.rd = rd; e.icyc = cyc;
        e.caddr = 12'h305;
        e.target = tv & ~32'd3;
        if (ev[3])      e.cmd = st ? 5'b11000 : 5'b10000;
        else if (ev[2]) e.cmd = 5'b00100;
        else if (ev[1]) e.cmd = 5'b00010;
        else begin
            e.cmd = 5'b00001; e.caddr = 12'h341; e.target = ep & ~32'd3;
        end
        if (!e.cmd[0]) model_cnt++;
        e.cnt = model_cnt;
        if (ev != 0) q.push_back(e);
        {is_misaligned, ebreak, ecall, mret} = ev;
        is_misalignment_store = st; pc = p; instr = ins; mem_addr = ma; rd_addr = rd;
        @(posedge clk); #1;
        {is_misaligned, ebreak, ecall, mret, is_misalignment_store} = '0;
    endtask

    // Pulse events while the DUT is busy; all must be ignored
    task automatic noise(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (stall && ($urandom % 3 == 0)) begin
                ecall = 1'($urandom % 2); mret = 1'($urandom % 2); is_misaligned = 1'b1;
                @(posedge clk); #1;
                {is_misaligned, ecall, mret} = '0;
            end
        end
    endtask

    task automatic wait_drain();
        int k = 0;
        while ((stall || q.size() != 0 || busy || pend_flush) && k < 300) begin @(posedge clk); #1; k++; end
        chk("drain", 256'(q.size()), 256'(0));
    endtask

    initial begin
        #1;
        chk("reset_outputs", all_outs(), 256'(0));
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        ready_mode = 1;
        issue(4'b0010, 0, 32'h100, 32'h0000_0073, 12'h0, 5'd0, 32'h200, 32'h0);
        issue(4'b0100, 0, 32'h204, 32'h0010_0073, 12'h0, 5'd0, 32'h201, 32'h0);
        issue(4'b1000, 1, 32'h308, 32'h00A1_2023, 12'h013, 5'd0, 32'h400, 32'h0);
        issue(4'b0001, 0, 32'h40C, 32'h3020_0073, 12'h0, 5'd0, 32'h400, 32'h106);
        wait_drain();

        // Coincident events, then ecalls while parked in REDIRECT
        ready_mode = 2;
        issue(4'b1011, 0, 32'h500, 32'h1234_5678, 12'h7FF, 5'd9, 32'h800, 32'h0);
        for (int k = 0; k < 20 && !redirect_valid; k++) begin @(posedge clk); #1; end
        for (int i = 0; i < 5; i++) begin
            ecall = 1'b1; @(posedge clk); #1; ecall = 1'b0;
            chk("hold_valid", 256'(redirect_valid), 256'(1));
            chk("hold_stall", 256'(stall), 256'(1));
            chk("hold_no_flush", 256'(flush), 256'(0));
        end
        ready_mode = 1;
        wait_drain();

        // Asynchronous reset in READ
        issue(4'b0010, 0, 32'h600, 32'h73, 12'h0, 5'd0, 32'h900, 32'h0);
        for (int k = 0; k < 10 && !csr_r_en; k++) begin @(posedge clk); #1; end
        chk("reached_read", 256'(csr_r_en), 256'(1));
        #1 rst = 1'b0;
        #1 chk("async_reset_outputs", all_outs(), 256'(0));
        q.delete(); model_cnt = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        issue(4'b0010, 0, 32'h700, 32'h73, 12'h0, 5'd0, 32'hA00, 32'h0);
        wait_drain();

        // Randomized traffic with random ready and busy-time noise
        ready_mode = 0;
        for (int t = 0; t < 40; t++) begin
            logic [3:0] ev;
            ev = 4'($urandom_range(1, 15));
            issue(ev, 1'($urandom % 2), $urandom, $urandom, 12'($urandom), 5'($urandom),
                  $urandom, $urandom);
            noise($urandom_range(0, 6));
        end
        ready_mode = 1;
        wait_drain();
        repeat (3) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
